// File: rtl/multiplier_controller_tt1_if.sv
// Handshake/strobe bundle between the shift-add multiplier controller and its datapath.
// Every strobe travels with a 1-bit taint companion.
interface multiplier_controller_tt1_if #(
  parameter int unsigned WIDTH = 1024
);
  logic             start;
  logic             start_t;
  logic [WIDTH-1:0] multiplierReg;
  logic             multiplierReg_t;
  logic             mrld;
  logic             mdld;
  logic             rsclear;
  logic             rsload;
  logic             rsshr;
  logic             busy;
  logic             done;
  logic             mrld_t;
  logic             mdld_t;
  logic             rsclear_t;
  logic             rsload_t;
  logic             rsshr_t;
  logic             busy_t;
  logic             done_t;

  modport master (
    output start, start_t, multiplierReg, multiplierReg_t,
    input  mrld, mdld, rsclear, rsload, rsshr, busy, done,
    input  mrld_t, mdld_t, rsclear_t, rsload_t, rsshr_t, busy_t, done_t
  );

  modport slave (
    input  start, start_t, multiplierReg, multiplierReg_t,
    output mrld, mdld, rsclear, rsload, rsshr, busy, done,
    output mrld_t, mdld_t, rsclear_t, rsload_t, rsshr_t, busy_t, done_t
  );
endinterface

// File: rtl/multiplier_controller_tt1.sv
// Control FSM for a sequential shift-add multiplier with sticky 1-bit taint tracking.
// Walks the multiplier word one bit per iteration and Moore-decodes datapath strobes.
module multiplier_controller_tt1 #(
  parameter int unsigned WIDTH = 1024
) (
  input logic                        clk,
  input logic                        rst_n,
  multiplier_controller_tt1_if.slave bus
);
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StTest, StAdd, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tnt_q, tnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tnt_q   <= tnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tnt_d   = tnt_q;
    unique case (state_q)
      StIdle: begin
        // An accepted start is the only event that can clear the taint.
        if (bus.start) begin
          state_d = StLoad;
          tnt_d   = bus.start_t;
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = StTest;
      end
      StTest: begin
        tnt_d   = tnt_q | bus.multiplierReg_t;
        state_d = bus.multiplierReg[cnt_q] ? StAdd : StShift;
      end
      StAdd:  state_d = StShift;
      StShift: begin
        if (cnt_q == CntLast) begin
          state_d = StDone;
        end else begin
          cnt_d   = cnt_q + CntW'(1);
          state_d = StTest;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bus.mrld    = (state_q == StLoad);
  assign bus.mdld    = (state_q == StLoad);
  assign bus.rsclear = (state_q == StLoad);
  assign bus.rsload  = (state_q == StAdd);
  assign bus.rsshr   = (state_q == StShift);
  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = (state_q == StDone);

  assign bus.mrld_t    = tnt_q;
  assign bus.mdld_t    = tnt_q;
  assign bus.rsclear_t = tnt_q;
  assign bus.rsload_t  = tnt_q;
  assign bus.rsshr_t   = tnt_q;
  assign bus.busy_t    = tnt_q;
  assign bus.done_t    = tnt_q;
endmodule

// File: doc/multiplier_controller_tt1.md
# multiplier_controller_tt1

Control FSM for the sequential shift-add multiplier with 1-bit taint tracking. It sits directly upstream of the multiplier datapath and drives the datapath's load, clear, add and shift strobes. It reads back the loaded multiplier word and steps through it one bit per iteration. Every strobe carries a companion 1-bit taint output, so information flow from tainted start requests and tainted multiplier bits into control decisions stays visible at the datapath.

## Interface
- WIDTH, 1024, operand width in bits; must match the datapath's WIDTH
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a multiply; accepted only in IDLE
- start_t  input  1  taint of start
- multiplierReg  input  WIDTH  loaded multiplier word from the datapath
- multiplierReg_t  input  1  taint of multiplierReg
- mrld, mdld  output  1 each  load multiplier / multiplicand registers
- rsclear  output  1  clear the running sum
- rsload  output  1  add the multiplicand into the running sum
- rsshr  output  1  arithmetic right-shift of the running sum
- mrld_t, mdld_t, rsclear_t, rsload_t, rsshr_t  output  1 each  taint of the matching strobe
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the product is valid
- busy_t, done_t  output  1 each  taint of busy / done

## Operation
- States: IDLE, LOAD, TEST, ADD, SHIFT, DONE. The bit counter cnt is $clog2(WIDTH) bits wide.
- All outputs are Moore-decoded from state:
  - LOAD: mrld=mdld=rsclear=1
  - ADD: rsload=1
  - SHIFT: rsshr=1
  - DONE: done=1
  - All other strobes are 0 in every state.
- At most one of rsclear, rsload, rsshr is high in any cycle.
- IDLE: if start=1, go to LOAD; otherwise stay in IDLE.
- LOAD: cnt <= 0; go to TEST.
- TEST: if multiplierReg[cnt]=1, go to ADD; otherwise go to SHIFT.
- ADD: go to SHIFT.
- SHIFT: if cnt==WIDTH-1, go to DONE; otherwise cnt <= cnt+1 and go to TEST.
- DONE: go to IDLE.
- start is ignored outside IDLE, and is not queued.
- A start that arrives while the FSM is in DONE is lost; it must be reasserted in IDLE.
- Taint register tnt:
  - On an accepted start, tnt <= start_t. This is the only way tnt clears short of reset.
  - In TEST, tnt <= tnt | multiplierReg_t, because the branch depends on the multiplier bit.
  - Otherwise tnt holds (sticky).
- Every *_t output equals tnt, regardless of whether the matching strobe is high.

## Timing
- Reset, asynchronous and valid at any point including mid-operation:
  - state=IDLE, cnt=0, tnt=0
  - every strobe, busy, done and every *_t output reads 0 immediately, without waiting for a clock edge
- Let start be sampled at edge 0. Then:
  - LOAD is active in the cycle after edge 0.
  - done rises after edge 1+2·WIDTH+popcount(multiplier) and is high for exactly one cycle.
  - busy is high from edge 0 until the edge that enters IDLE.
- multiplierReg is loaded at the edge that leaves LOAD, so the first TEST sees the new value.
- Datapath product is valid in the DONE cycle and stays valid afterwards until the next LOAD.
- rst_n deassertion: the first edge with rst_n=1 may accept start.

## Test plan
- WIDTH=4, start with multiplier 4'b1011, start_t=0, multiplierReg_t=0:
  - strobe order: LOAD, T, A, S, T, A, S, T, S, T, A, S, DONE
  - done is seen 12 edges after start; all *_t outputs stay 0
  - with the datapath attached and multiplicand 4'd5, product = 55
- WIDTH=4, multiplier 0 → rsload is never asserted, done arrives at edge 9. Multiplier 4'hF → done arrives at edge 13.
- start_t=1 on acceptance → every *_t output is 1 from LOAD through DONE and while idle afterwards. The next start with start_t=0 clears them in LOAD.
- start_t=0, multiplierReg_t=1 → *_t outputs are 0 in LOAD and TEST0, and 1 from the cycle after the first TEST onward.
- start held high continuously → a new LOAD follows each DONE→IDLE with one IDLE cycle between them. start pulsed mid-run → no effect on cnt or the strobe sequence.
- rst_n pulled low during an ADD → outputs drop to 0 asynchronously. After release, start begins a fresh LOAD with cnt=0.
